if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage. It holds the PC and looks it up in a direct-mapped instruction cache. On a miss it fetches the word through a req/ack port on the memory controller. It presents {if_pc, if_inst} to the IF/ID pipeline register, requests a bubble while no instruction is available, and redirects on taken branches and jumps that the decode stage resolves.

Parameters:
IDX_W, 6, cache index width; the cache has 2^IDX_W one-word lines.
ADDR_W, 17, byte address width of instruction memory.
RESET_PC, 17'h0, PC value after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; when low, all state freezes
hold  in  1  downstream stall (stall[1]); PC must not advance
redirect  in  1  use_npc from decode; branch or jump taken
redirect_pc  in  ADDR_W  npc_addr from decode
if_pc  out  ADDR_W  PC of the presented instruction
if_inst  out  32  instruction; 32'h0 means bubble
stall_req  out  1  drives stall[0]; asks IF/ID to latch a bubble
mem_req  out  1  fetch request; held high until mem_ack
mem_addr  out  ADDR_W  word-aligned fetch address; stable while mem_req is high
mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle
mem_rdata  in  32  returned instruction word

Behaviour:
- PC bits [1:0] are always forced to 00. The low two bits of redirect_pc are ignored.
- Cache line contents: valid bit, tag = pc[ADDR_W-1:IDX_W+2], data 32 bits. Index = pc[IDX_W+1:2]. Lookup is combinational from the pc register.
- States: FETCH, MISS, DISCARD.
- FETCH, hit, no redirect:
  - if_inst = line data, if_pc = pc, stall_req = 0.
  - If hold is low, pc <= pc+4 (wraps modulo 2^ADDR_W).
- FETCH, miss, no redirect:
  - if_inst = 0, stall_req = 1.
  - Next state is MISS. mem_req and mem_addr = pc are asserted from the next cycle.
- MISS:
  - mem_req = 1, stall_req = 1, if_inst = 0.
  - On mem_ack: write {valid, tag, mem_rdata} into the line. Present if_inst = mem_rdata, if_pc = pc, stall_req = 0 in the same cycle.
  - On mem_ack with hold low: pc <= pc+4. With hold high: pc is unchanged, and the next cycle hits.
  - After mem_ack, state returns to FETCH.
- Redirect handling:
  - In any state, redirect has priority over advancing the PC: pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - In the redirect cycle, if_inst = 0 and stall_req = 1 (the wrong-path instruction is squashed). This applies even when hold is high.
  - Redirect in FETCH: state stays FETCH.
  - Redirect in MISS: the outstanding request cannot be cancelled. The old address is latched into miss_addr and the state goes to DISCARD.
- DISCARD:
  - mem_req = 1, mem_addr = miss_addr, stall_req = 1, if_inst = 0.
  - On mem_ack: the line is filled for miss_addr, nothing is delivered, and state goes to FETCH.
  - A further redirect while in DISCARD updates only pc.
- mem_addr comes from a register: pc in MISS, miss_addr in DISCARD.
- Cycle accounting:
  - Hit: latency 0; one instruction per cycle when not held.
  - Miss: 1 lookup cycle + memory latency. The instruction is delivered in the mem_ack cycle.
- rdy low: pc, state, cache and miss_addr all freeze. Outputs keep their values, and mem_req stays asserted if it was asserted.
- Reset:
  - pc = RESET_PC, state = FETCH, all valid bits cleared in one cycle.
  - Outputs: if_pc = 0, if_inst = 0, stall_req = 0, mem_req = 0, mem_addr = 0.
  - Reset during MISS or DISCARD drops mem_req in the next cycle. The memory controller is reset by the same rst.
- A mem_ack that arrives while in FETCH is ignored.
- No self-modifying-code support; there is no flush port.

Decomposition:
- defines.v gains:
  - `ICacheIdxW
  - `InstAddrBus (16:0)
  - state encodings `IF_FETCH = 2'd0, `IF_MISS = 2'd1, `IF_DISCARD = 2'd2
  - It reuses the existing `InstBus and `ZeroWord.
- Sub-module icache:
  - Holds the valid vector, tag array and data array.
  - Ports: clk, rst, rdy, raddr, hit, rdata, we, waddr, wdata.
  - The read is combinational. The write is synchronous.
- if_stage contains the FSM, the pc register and the redirect logic.

Test Plan:
1. Reset, then memory returns 32'h00000013 at address 0 after 3 cycles. Required: stall_req is high for 4 cycles, then if_pc=0 and if_inst=32'h00000013 in the ack cycle; next mem_addr=4.
2. Loop 0→4→8, then redirect_pc=0 on the second pass. Required: addresses 0, 4 and 8 hit, with no mem_req and one instruction per cycle.
3. Redirect to 17'h100 while in MISS for address 8. Required: the ack for 8 is not delivered (if_inst=0) but is cached. Then a fetch for 0x100 is issued; re-fetching 8 later hits.
4. hold high during the ack cycle at pc=0x20. Required: pc stays 0x20 and the next cycle hits with the same instruction; pc advances only after hold falls.
5. Aliasing: 0x000 and 0x100 (IDX_W=6) share a line. Required: each access misses alternately, and data always matches the correct address.
6. rdy low for 5 cycles mid-miss, then rst asserted during MISS. Required: all state is frozen while rdy is low. After rst, mem_req=0, pc=0, and all lines are invalid, so the next access misses.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Fetch FSM states, cache geometry and the instruction bus zero word.
package if_stage_pkg;

  localparam int ICACHE_IDX_W = 6;
  localparam int INST_ADDR_W  = 17;

  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic [1:0] {
    IF_FETCH   = 2'd0,
    IF_MISS    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped one-word-per-line instruction cache.
// Ports: clk, rst, rdy, raddr/hit/rdata (comb read), we/waddr/wdata (sync write).
module if_stage_icache
  import if_stage_pkg::*;
#(
  parameter int IDX_W  = ICACHE_IDX_W,
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-3:0] raddr,
  output logic              hit,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-3:0] waddr,
  input  logic [31:0]       wdata
);

  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic [TAG_W-1:0] rtag;
  logic [TAG_W-1:0] wtag;

  assign ridx = raddr[IDX_W-1:0];
  assign rtag = raddr[ADDR_W-3:IDX_W];
  assign widx = waddr[IDX_W-1:0];
  assign wtag = waddr[ADDR_W-3:IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy && we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign hit   = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign rdata = data_q[ridx];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, icache lookup, miss refill via req/ack, redirects.
// Ports: clk/rst/rdy, hold, redirect(_pc), if_pc/if_inst/stall_req, mem_*.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              IDX_W    = ICACHE_IDX_W,
  parameter int              ADDR_W   = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              hold,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              stall_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  if_state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] rpc;
  logic              hit;
  logic [31:0]       rdata;
  logic              we;
  logic              ack;
  logic              redir;
  logic [31:0]       inst;
  logic              stall;

  // With rdy low nothing may move, including the outputs.
  assign ack    = mem_ack & rdy;
  assign redir  = redirect & rdy;
  assign pc_inc = pc_q + ADDR_W'(4);
  assign rpc    = redirect_pc & ~ADDR_W'(3);

  if_stage_icache #(
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) u_icache (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .raddr (pc_q[ADDR_W-1:2]),
    .hit   (hit),
    .rdata (rdata),
    .we    (we),
    .waddr (addr_q[ADDR_W-1:2]),
    .wdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst    = ZERO_WORD;
    stall   = 1'b1;
    we      = 1'b0;
    unique case (state_q)
      IF_FETCH: begin
        if (redir) begin
          pc_d = rpc;
        end else if (hit) begin
          inst  = rdata;
          stall = 1'b0;
          if (!hold) pc_d = pc_inc;
        end else begin
          state_d = IF_MISS;
          addr_d  = pc_q;
        end
      end
      IF_MISS: begin
        if (ack) begin
          // The refill is kept even when the word is squashed.
          we      = 1'b1;
          state_d = IF_FETCH;
          if (redir) begin
            pc_d = rpc;
          end else begin
            inst  = mem_rdata;
            stall = 1'b0;
            if (!hold) pc_d = pc_inc;
          end
        end else if (redir) begin
          // The request cannot be withdrawn; addr_q keeps the old line.
          pc_d    = rpc;
          state_d = IF_DISCARD;
        end
      end
      IF_DISCARD: begin
        if (ack) begin
          we      = 1'b1;
          state_d = IF_FETCH;
        end
        if (redir) pc_d = rpc;
      end
      default: state_d = IF_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_FETCH;
      pc_q    <= RESET_PC & ~ADDR_W'(3);
      addr_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign if_pc     = rst ? '0 : pc_q;
  assign if_inst   = rst ? ZERO_WORD : inst;
  assign stall_req = ~rst & stall;
  assign mem_req   = (state_q != IF_FETCH);
  assign mem_addr  = addr_q;

endmodule
